// File: rtl/alu_result_collector_if.sv
// Handshake bundle between the ALU result producer, the collector FIFO and its downstream consumer.
// master = producer/consumer environment, slave = the collector.
interface alu_result_collector_if #(
    parameter int DATA_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] result;
    logic              ZF;
    logic              OP;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_zf;
    logic              out_op;

    modport master (
        output in_valid, result, ZF, OP, out_ready,
        input  in_ready, out_valid, out_result, out_zf, out_op
    );

    modport slave (
        input  in_valid, result, ZF, OP, out_ready,
        output in_ready, out_valid, out_result, out_zf, out_op
    );
endinterface

// File: rtl/alu_result_collector.sv
// Captures ALU results {OP,ZF,result} into a small FIFO and keeps running statistics
// (modular accumulator, saturating zero-flag count, sticky drop error).
module alu_result_collector #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    alu_result_collector_if.slave    bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DATA_W-1:0]        acc,
    output logic [CNT_W-1:0]         zero_cnt,
    output logic                     drop_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + 2;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
    logic             drop_err_q, drop_err_d;
    logic             push, pop;
    logic             full, empty;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Flags come only from the registered level, so there is no in->out combinational path.
    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign push  = bus.in_valid & ~full;
    assign pop   = bus.out_ready & ~empty;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        acc_d      = acc_q;
        zero_cnt_d = zero_cnt_q;
        drop_err_d = drop_err_q | (bus.in_valid & full);
        if (push) begin
            mem_d[wr_ptr_q] = {bus.OP, bus.ZF, bus.result};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            acc_d           = acc_q + bus.result;
            if (bus.ZF) zero_cnt_d = sat_inc(zero_cnt_q);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop) level_d = level_q + LVL_W'(1);
        else if (pop && !push) level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            acc_q      <= '0;
            zero_cnt_q <= '0;
            drop_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            acc_q      <= acc_d;
            zero_cnt_q <= zero_cnt_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Storage holds data only; its contents are don't-care after reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready   = ~full;
    assign bus.out_valid  = ~empty;
    assign bus.out_result = mem_q[rd_ptr_q][DATA_W-1:0];
    assign bus.out_zf     = mem_q[rd_ptr_q][DATA_W];
    assign bus.out_op     = mem_q[rd_ptr_q][DATA_W+1];
    assign level          = level_q;
    assign acc            = acc_q;
    assign zero_cnt       = zero_cnt_q;
    assign drop_err       = drop_err_q;
endmodule

// File: tb/tb_alu_result_collector.sv
// Directed self-checking bench for alu_result_collector: reset, ordering, full/drop,
// pop-while-full, wrap under simultaneous push/pop, mid-stream reset, zero-count saturation.
module tb_alu_result_collector;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] level;
    logic [5:0] acc;
    logic [7:0] zero_cnt;
    logic       drop_err;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         exp_heads [6] = '{2, 3, 10, 11, 12, 13};

    alu_result_collector_if #(.DATA_W(6)) bus ();

    alu_result_collector #(.DATA_W(6), .DEPTH(4), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .level    (level),
        .acc      (acc),
        .zero_cnt (zero_cnt),
        .drop_err (drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] r, input logic z, input logic o, input logic rdy);
        bus.in_valid  = v;
        bus.result    = r;
        bus.ZF        = z;
        bus.OP        = o;
        bus.out_ready = rdy;
    endtask

    task automatic do_reset();
        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        #1;
        do_reset();
        check("rst_level", level, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_acc", acc, 0);
        check("rst_zero_cnt", zero_cnt, 0);
        check("rst_drop_err", drop_err, 0);

        // Two pushes then drain in order
        drive(1'b1, 6'd5, 1'b0, 1'b0, 1'b0);
        step();
        check("t2_lvl1", level, 1);
        check("t2_valid1", bus.out_valid, 1);
        check("t2_head_lat", bus.out_result, 5);
        drive(1'b1, 6'd0, 1'b1, 1'b1, 1'b0);
        step();
        check("t2_lvl2", level, 2);
        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
        check("t2_h0_res", bus.out_result, 5);
        check("t2_h0_zf", bus.out_zf, 0);
        check("t2_h0_op", bus.out_op, 0);
        step();
        check("t2_h1_res", bus.out_result, 0);
        check("t2_h1_zf", bus.out_zf, 1);
        check("t2_h1_op", bus.out_op, 1);
        check("t2_lvl_after1", level, 1);
        step();
        check("t2_lvl0", level, 0);
        check("t2_empty", bus.out_valid, 0);
        check("t2_acc", acc, 5);
        check("t2_zero_cnt", zero_cnt, 1);
        step();
        check("t2_empty_pop_ignored", level, 0);

        // Fill to full, then overflow
        do_reset();
        drive(1'b1, 6'd63, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 6'd1,  1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 6'd2,  1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 6'd3,  1'b0, 1'b0, 1'b0); step();
        check("t3_lvl_full", level, 4);
        check("t3_in_ready", bus.in_ready, 0);
        check("t3_no_drop_yet", drop_err, 0);
        drive(1'b1, 6'd7, 1'b1, 1'b0, 1'b0);
        step();
        check("t3_drop_err", drop_err, 1);
        check("t3_lvl_still_full", level, 4);
        check("t3_acc", acc, 5);
        check("t3_zero_cnt", zero_cnt, 0);

        // Full with in_valid and out_ready together: pop only
        check("t4_head_before", bus.out_result, 63);
        drive(1'b1, 6'd9, 1'b0, 1'b0, 1'b1);
        step();
        check("t4_lvl", level, 3);
        check("t4_drop_err", drop_err, 1);
        check("t4_acc", acc, 5);
        check("t4_head_after", bus.out_result, 1);
        check("t4_in_ready", bus.in_ready, 1);

        // Drain one to level 2, then six cycles of push+pop across the wrap
        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
        step();
        check("t5_lvl_start", level, 2);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t5_head%0d", i), bus.out_result, exp_heads[i]);
            drive(1'b1, 6'(10 + i), 1'b1, 1'b0, 1'b1);
            step();
            check($sformatf("t5_lvl%0d", i), level, 2);
        end
        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        check("t5_head_final", bus.out_result, 14);
        check("t5_head_final_zf", bus.out_zf, 1);
        check("t5_acc", acc, 16);
        check("t5_zero_cnt", zero_cnt, 6);

        // Mid-stream reset at level 3, with a push presented during reset
        drive(1'b1, 6'd20, 1'b0, 1'b0, 1'b0);
        step();
        check("t6_lvl3", level, 3);
        reset = 1'b0;
        drive(1'b1, 6'd21, 1'b1, 1'b0, 1'b1);
        step();
        check("t6_lvl", level, 0);
        check("t6_acc", acc, 0);
        check("t6_out_valid", bus.out_valid, 0);
        check("t6_drop_err", drop_err, 0);
        check("t6_zero_cnt", zero_cnt, 0);
        reset = 1'b1;
        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

        // Zero-flag count saturates at 255
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 6'd0, 1'b1, 1'b0, 1'b1);
            step();
        end
        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        check("sat_zero_cnt", zero_cnt, 255);
        check("sat_lvl", level, 1);
        check("sat_acc", acc, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
